// File: rtl/j_cnte_mod.sv
// Modulo up/down counter with enable, synchronous clear/load, wrap or saturate mode,
// a registered terminal-count pulse and a combinational carry-out for cascading stages.
module j_cnte_mod #(
    parameter int WIDTH    = 3,
    parameter int MODULUS  = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] ldval,
    input  logic             cnten,
    input  logic             up,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             cnto
);

    if (WIDTH < 1 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_param_check
        $error("j_cnte_mod: illegal WIDTH=%0d / MODULUS=%0d", WIDTH, MODULUS);
    end

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             at_term;
    logic             step;

    // The terminal value follows the direction sampled this cycle, so a reversal
    // re-targets the wrap/saturate point on the same edge.
    assign at_term = (count_q == (up ? MAX_VAL : '0));
    assign step    = ~clr & ~load & cnten;
    assign cnto    = step & at_term;

    always_comb begin
        // NOTE: defaulting every output of a combinational block first prevents latch inference.
        count_d = count_q;
        tc_d    = step & at_term;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = (ldval > MAX_VAL) ? MAX_VAL : ldval;
        end else if (step) begin
            if (!at_term) begin
                count_d = up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
            end else if (!SATURATE) begin
                count_d = up ? '0 : MAX_VAL;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;

endmodule

// File: tb/tb_j_cnte_mod.sv
// Self-checking bench: three counter variants in lockstep plus a two-digit decimal cascade,
// compared every cycle against an arithmetic reference model.
module tb_j_cnte_mod;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       clr = 1'b0, load = 1'b0, cnten = 1'b0, up = 1'b1, casc_en = 1'b0;
    logic [3:0] ldval = 4'd0;

    logic [2:0] cnt_a;
    logic [3:0] cnt_b, cnt_s, c0, c1;
    logic       tc_a, tc_b, tc_s, tc0, tc1;
    logic       cnto_a, cnto_b, cnto_s, cnto0, cnto1;

    always #5 clk = ~clk;

    j_cnte_mod #(.WIDTH(3), .MODULUS(8), .SATURATE(1'b0)) u_a (
        .clk(clk), .reset_n(reset_n), .clr(clr), .load(load), .ldval(ldval[2:0]),
        .cnten(cnten), .up(up), .count(cnt_a), .tc(tc_a), .cnto(cnto_a));

    j_cnte_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_b (
        .clk(clk), .reset_n(reset_n), .clr(clr), .load(load), .ldval(ldval),
        .cnten(cnten), .up(up), .count(cnt_b), .tc(tc_b), .cnto(cnto_b));

    j_cnte_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_s (
        .clk(clk), .reset_n(reset_n), .clr(clr), .load(load), .ldval(ldval),
        .cnten(cnten), .up(up), .count(cnt_s), .tc(tc_s), .cnto(cnto_s));

    j_cnte_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_c0 (
        .clk(clk), .reset_n(reset_n), .clr(1'b0), .load(1'b0), .ldval(4'd0),
        .cnten(casc_en), .up(1'b1), .count(c0), .tc(tc0), .cnto(cnto0));

    j_cnte_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_c1 (
        .clk(clk), .reset_n(reset_n), .clr(1'b0), .load(1'b0), .ldval(4'd0),
        .cnten(cnto0), .up(1'b1), .count(c1), .tc(tc1), .cnto(cnto1));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: plain integers for each counter, the cascade as one number 0..99.
    int ma = 0, mb = 0, ms = 0, mc = 0;
    bit ea = 0, eb = 0, es = 0, e0 = 0, e1 = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit term_step(int c, int m);
        return !clr && !load && cnten && (c == (up ? m - 1 : 0));
    endfunction

    function automatic int next_val(int c, int m, bit sat, int ld);
        if (clr) return 0;
        if (load) return (ld >= m) ? m - 1 : ld;
        if (!cnten) return c;
        if (sat && term_step(c, m)) return c;
        return up ? (c + 1) % m : (c + m - 1) % m;
    endfunction

    task automatic check_regs();
        check("count_a", cnt_a, ma);
        check("count_b", cnt_b, mb);
        check("count_s", cnt_s, ms);
        check("tc_a", tc_a, ea);
        check("tc_b", tc_b, eb);
        check("tc_s", tc_s, es);
        check("casc_lo", c0, mc % 10);
        check("casc_hi", c1, mc / 10);
        check("casc_tc0", tc0, e0);
        check("casc_tc1", tc1, e1);
    endtask

    task automatic tick();
        int na, nb, ns, nc;
        bit ta, tb, ts, t0, t1;
        #1;
        ta = term_step(ma, 8);
        tb = term_step(mb, 10);
        ts = term_step(ms, 10);
        t0 = casc_en && (mc % 10 == 9);
        t1 = t0 && (mc / 10 == 9);
        check("cnto_a", cnto_a, ta);
        check("cnto_b", cnto_b, tb);
        check("cnto_s", cnto_s, ts);
        check("casc_cnto0", cnto0, t0);
        check("casc_cnto1", cnto1, t1);
        na = next_val(ma, 8, 1'b0, int'(ldval) % 8);
        nb = next_val(mb, 10, 1'b0, int'(ldval));
        ns = next_val(ms, 10, 1'b1, int'(ldval));
        nc = casc_en ? (mc + 1) % 100 : mc;
        @(posedge clk);
        #1;
        ma = na; mb = nb; ms = ns; mc = nc;
        ea = ta; eb = tb; es = ts; e0 = t0; e1 = t1;
        check_regs();
    endtask

    // Asserts reset between edges and expects every register to clear before the next edge.
    task automatic mid_cycle_reset();
        #2 reset_n = 1'b0;
        #1;
        ma = 0; mb = 0; ms = 0; mc = 0;
        ea = 0; eb = 0; es = 0; e0 = 0; e1 = 0;
        check_regs();
        #2 reset_n = 1'b1;
    endtask

    initial begin
        int pulses;
        #1;
        check_regs();
        #11 reset_n = 1'b1;

        // T1: load 5, then reset mid-cycle; idle after release keeps 0.
        load = 1'b1; ldval = 4'd5;
        tick();
        check("t1_loaded", cnt_a, 3'd5);
        load = 1'b0; cnten = 1'b0;
        mid_cycle_reset();
        tick();
        check("t1_idle", cnt_a, 3'd0);

        // T2: nine up-steps from 0 wrap through 7 -> 0 -> 1.
        cnten = 1'b1; up = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        check("t2_end", cnt_a, 3'd1);

        // T3: out-of-range load clamps, then count down across 0.
        cnten = 1'b0; load = 1'b1; ldval = 4'd12;
        tick();
        check("t3_clamp", cnt_b, 4'd9);
        ldval = 4'd1;
        tick();
        load = 1'b0; cnten = 1'b1; up = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("t3_down", cnt_b, 4'd8);

        // T4: saturate holds at 9 with tc each cycle after a terminal step.
        cnten = 1'b0; load = 1'b1; ldval = 4'd8;
        tick();
        load = 1'b0; cnten = 1'b1; up = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("t4_sat", cnt_s, 4'd9);
        check("t4_tc", tc_s, 1'b1);

        // T5: clr beats load beats count.
        cnten = 1'b0; load = 1'b1; ldval = 4'd3;
        tick();
        clr = 1'b1; ldval = 4'd6; cnten = 1'b1;
        tick();
        check("t5_clr", cnt_b, 4'd0);
        check("t5_tc", tc_b, 1'b0);
        clr = 1'b0;
        tick();
        check("t5_load", cnt_b, 4'd6);
        load = 1'b0;
        tick();
        check("t5_count", cnt_b, 4'd7);

        // T6: decimal cascade 00..99 -> 00 with one high-digit tc pulse.
        cnten = 1'b0;
        mid_cycle_reset();
        casc_en = 1'b1;
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            pulses += int'(tc1);
        end
        check("t6_wrap", {c1, c0}, 8'h00);
        check("t6_pulses", pulses, 1);

        // Random traffic on all instances.
        for (int i = 0; i < 400; i++) begin
            clr     = ($urandom_range(15) == 0);
            load    = ($urandom_range(7) == 0);
            cnten   = ($urandom_range(3) != 0);
            up      = $urandom_range(1);
            ldval   = 4'($urandom_range(15));
            casc_en = ($urandom_range(3) != 0);
            tick();
            if (i == 200) mid_cycle_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
